// File: rtl/positround_accumprod_16_raw_pkg.sv
// Shared widths, field layout and posit16/es2 constants for the
// accumulator-to-posit16 output stage.
package positround_accumprod_16_raw_pkg;

  localparam int ABITS_ACCUM = 9;
  localparam int FBITS_ACCUM = 147;
  localparam int POSIT_SERIALIZED_WIDTH_ACCUM_PROD_ES2 = 1 + ABITS_ACCUM + FBITS_ACCUM + 2;

  localparam int          POSIT16_ES2_MAX_SCALE = 56;
  localparam logic [15:0] POSIT16_NAR           = 16'h8000;

  // Posit body excludes the sign bit. The regime is at most 15 bits long
  // once saturated scales are excluded.
  localparam int BODY_BITS   = 15;
  localparam int RLEN_BITS   = 4;
  localparam int BUILD_WIDTH = BODY_BITS + 2 + FBITS_ACCUM;

  typedef struct packed {
    logic                          sgn;
    logic signed [ABITS_ACCUM-1:0] scale;
    logic [FBITS_ACCUM-1:0]        fraction;
    logic                          inf;
    logic                          zero;
  } value_accum_prod;

endpackage

// File: rtl/positround_accumprod_16_raw_round.sv
// Round-to-nearest-even on a 15-bit posit body. The result is kept inside
// minpos..maxpos so rounding never produces zero or NaR.
module posit16_es2_round_nearest_even
  import positround_accumprod_16_raw_pkg::*;
(
  input  logic [BODY_BITS-1:0] body,
  input  logic                 guard,
  input  logic                 sticky,
  output logic [BODY_BITS-1:0] body_r,
  output logic                 inexact
);

  logic             inc;
  logic [BODY_BITS:0] sum;

  assign inc     = guard & (body[0] | sticky);
  assign sum     = {1'b0, body} + {{BODY_BITS{1'b0}}, inc};
  assign inexact = guard | sticky;

  // NOTE: every output of a combinational block gets a default on each path, so no latch is inferred.
  always_comb begin
    body_r = sum[BODY_BITS-1:0];
    if (sum[BODY_BITS])
      body_r = '1;
    else if (sum[BODY_BITS-1:0] == '0)
      body_r = BODY_BITS'(1);
  end

endmodule

// File: rtl/shift_right.sv
// Generic logical right shifter.
module shift_right #(
  parameter int WIDTH       = 8,
  parameter int SHIFT_WIDTH = 3
) (
  input  logic [WIDTH-1:0]       value,
  input  logic [SHIFT_WIDTH-1:0] amount,
  output logic [WIDTH-1:0]       shifted
);

  assign shifted = value >> amount;

endmodule

// File: rtl/positround_accumprod_16_raw.sv
// Encodes a raw accumulator value into a 16-bit es=2 posit. Four register
// stages: decode, regime build/shift, round, finalize.
module positround_accumprod_16_raw
  import positround_accumprod_16_raw_pkg::*;
#(
  parameter int LATENCY   = 4,
  parameter int MAX_SCALE = POSIT16_ES2_MAX_SCALE
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic [POSIT_SERIALIZED_WIDTH_ACCUM_PROD_ES2-1:0] in1,
  input  logic                                             truncated_in,
  input  logic                                             start,
  output logic [15:0]                                      result,
  output logic                                             done,
  output logic                                             inexact
);

  localparam logic signed [ABITS_ACCUM-1:0] SAT_HI_SCALE = ABITS_ACCUM'(MAX_SCALE - 1);
  localparam logic signed [ABITS_ACCUM-1:0] SAT_LO_SCALE = ABITS_ACCUM'(-MAX_SCALE);

  value_accum_prod fields;
  assign fields = in1;

  logic [LATENCY-1:0] valid_pipe;
  assign done = valid_pipe[LATENCY-1];

  // Stage 1: decode
  logic                          s1_sgn, s1_inf, s1_zero, s1_trunc, s1_sat_hi, s1_sat_lo;
  logic signed [ABITS_ACCUM-1:0] s1_k;
  logic [1:0]                    s1_e;
  logic [FBITS_ACCUM-1:0]        s1_frac;

  // Stage 2: regime build and alignment
  logic [RLEN_BITS-1:0]   rlen, run_len;
  logic [BODY_BITS-1:0]   regime;
  logic [BUILD_WIDTH-1:0] shifted, built;

  always_comb begin
    rlen = RLEN_BITS'(15);
    if (!s1_k[ABITS_ACCUM-1]) begin
      if (s1_k <= 9'sd12) rlen = RLEN_BITS'(s1_k + 9'sd2);
    end else begin
      if (s1_k >= -9'sd13) rlen = RLEN_BITS'(9'sd1 - s1_k);
    end
  end

  // The run (ones for k>=0, zeros for k<0) is one shorter than the regime.
  assign run_len = rlen - RLEN_BITS'(1);
  assign regime  = s1_k[ABITS_ACCUM-1] ? (15'h4000 >> run_len) : ~(15'h7FFF >> run_len);

  shift_right #(
    .WIDTH       (BUILD_WIDTH),
    .SHIFT_WIDTH (RLEN_BITS)
  ) u_shift (
    .value   ({s1_e, s1_frac, {BODY_BITS{1'b0}}}),
    .amount  (rlen),
    .shifted (shifted)
  );

  assign built = shifted | {regime, {(BUILD_WIDTH-BODY_BITS){1'b0}}};

  logic                 s2_sgn, s2_inf, s2_zero, s2_sat_hi, s2_sat_lo, s2_guard, s2_sticky;
  logic [BODY_BITS-1:0] s2_body;

  // Stage 3: round
  logic [BODY_BITS-1:0] body_r;
  logic                 inexact_n;

  posit16_es2_round_nearest_even u_round (
    .body    (s2_body),
    .guard   (s2_guard),
    .sticky  (s2_sticky),
    .body_r  (body_r),
    .inexact (inexact_n)
  );

  logic                 s3_sgn, s3_inf, s3_zero, s3_sat_hi, s3_sat_lo, s3_inexact_n;
  logic [BODY_BITS-1:0] s3_body_r;

  // NOTE: datapath registers carry no reset; only the valid bits and visible outputs need one.
  always_ff @(posedge clk) begin
    if (start) begin
      s1_sgn    <= fields.sgn;
      s1_inf    <= fields.inf;
      s1_zero   <= fields.zero;
      s1_trunc  <= truncated_in;
      s1_sat_hi <= fields.scale > SAT_HI_SCALE;
      s1_sat_lo <= fields.scale < SAT_LO_SCALE;
      s1_k      <= fields.scale >>> 2;
      s1_e      <= fields.scale[1:0];
      s1_frac   <= fields.fraction;
    end
    if (valid_pipe[0]) begin
      s2_sgn    <= s1_sgn;
      s2_inf    <= s1_inf;
      s2_zero   <= s1_zero;
      s2_sat_hi <= s1_sat_hi;
      s2_sat_lo <= s1_sat_lo;
      s2_body   <= built[BUILD_WIDTH-1 -: BODY_BITS];
      s2_guard  <= built[BUILD_WIDTH-1-BODY_BITS];
      s2_sticky <= (|built[BUILD_WIDTH-2-BODY_BITS:0]) | s1_trunc;
    end
    if (valid_pipe[1]) begin
      s3_sgn       <= s2_sgn;
      s3_inf       <= s2_inf;
      s3_zero      <= s2_zero;
      s3_sat_hi    <= s2_sat_hi;
      s3_sat_lo    <= s2_sat_lo;
      s3_body_r    <= body_r;
      s3_inexact_n <= inexact_n;
    end
  end

  // Stage 4: specials, saturation and sign
  logic [BODY_BITS-1:0] mag;
  logic [15:0]          final_result, unsigned_result;
  logic                 final_inexact;

  assign unsigned_result = {1'b0, mag};

  always_comb begin
    mag           = s3_body_r;
    final_inexact = s3_inexact_n;
    if (s3_sat_hi) begin
      mag           = '1;
      final_inexact = 1'b1;
    end else if (s3_sat_lo) begin
      mag           = BODY_BITS'(1);
      final_inexact = 1'b1;
    end
    final_result = s3_sgn ? (~unsigned_result + 16'd1) : unsigned_result;
    if (s3_inf) begin
      final_result  = POSIT16_NAR;
      final_inexact = 1'b0;
    end else if (s3_zero) begin
      final_result  = 16'h0000;
      final_inexact = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all stages advance together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_pipe <= '0;
      result     <= 16'h0000;
      inexact    <= 1'b0;
    end else begin
      // An if keeps an X on start from propagating into the valid chain.
      if (start) valid_pipe <= {valid_pipe[LATENCY-2:0], 1'b1};
      else       valid_pipe <= {valid_pipe[LATENCY-2:0], 1'b0};
      if (valid_pipe[LATENCY-2]) begin
        result  <= final_result;
        inexact <= final_inexact;
      end
    end
  end

endmodule
